// File: rtl/rf_scoreboard.sv
// Register file with per-register busy scoreboard: issue marks a destination busy,
// writeback clears it; reads and hazard checks optionally see same-cycle writebacks.
module rf_scoreboard #(
  parameter int  XLEN     = 32,
  parameter int  NREG     = 32,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            RST,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            USE1,
  input  logic            USE2,
  input  logic            ISS_V,
  input  logic [AW-1:0]   ISS_RD,
  input  logic            ISS_WR,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            ISS_ACK,
  output logic [AW:0]     PEND_CNT,
  output logic            WB_ERR
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pend_cnt_q, pend_cnt_d;
  logic            wb_err_q, wb_err_d;

  logic hit1, hit2, hitd;
  logic zero1, zero2, zerod, zero3;
  logic b1, b2, bd;
  logic iss_set, mem_we;

  // A writeback in flight this cycle counts as already landed when bypassing.
  assign hit1  = BYPASS && WE3 && (A3 == A1);
  assign hit2  = BYPASS && WE3 && (A3 == A2);
  assign hitd  = BYPASS && WE3 && (A3 == ISS_RD);
  assign zero1 = ZERO_REG && (A1 == '0);
  assign zero2 = ZERO_REG && (A2 == '0);
  assign zerod = ZERO_REG && (ISS_RD == '0);
  assign zero3 = ZERO_REG && (A3 == '0);

  assign b1 = busy_q[A1] & ~hit1 & ~zero1;
  assign b2 = busy_q[A2] & ~hit2 & ~zero2;
  assign bd = busy_q[ISS_RD] & ~hitd & ~zerod;

  assign STALL   = ISS_V & ((USE1 & b1) | (USE2 & b2) | (ISS_WR & bd));
  assign ISS_ACK = ISS_V & ~STALL;
  assign iss_set = ISS_ACK & ISS_WR & ~zerod;
  assign mem_we  = WE3 & ~zero3;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    RD1 = mem_q[A1];
    if (hit1)  RD1 = WD3;
    if (zero1) RD1 = '0;
    RD2 = mem_q[A2];
    if (hit2)  RD2 = WD3;
    if (zero2) RD2 = '0;
  end

  // Order matters: issue set beats writeback clear, flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (WE3)      busy_d[A3]     = 1'b0;
    if (iss_set)  busy_d[ISS_RD] = 1'b1;
    if (FLUSH)    busy_d         = '0;
    if (ZERO_REG) busy_d[0]      = 1'b0;
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, busy_d[i]};
  end

  assign wb_err_d = wb_err_q | (WE3 & ~busy_q[A3] & ~zero3);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  // NOTE: the register array is reset because architectural state must read 0 after reset; this costs a reset net per flop.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[A3] <= WD3;
    end
  end

  assign PEND_CNT = pend_cnt_q;
  assign WB_ERR   = wb_err_q;

endmodule
